decode_fwd_stage: RTL and testbench
===================================

Name: decode_fwd_stage

Overview:
Parametrised successor of the MIPS pipeline decode stage. Contains:
- Register file of configurable width and depth.
- Internal forwarding unit that replaces the externally driven mux controls.
- Load-use interlock.
- Branch resolution in ID.
- Registered ID/EX pipeline output with hold and flush.

It sits between the IF/ID register and the execute stage. It takes the EX, MEM and WB stages as forwarding sources.

Parameters:
- DATA_W, 32, register/operand width in bits.
- REG_AW, 5, register address width; 2**REG_AW registers; register 0 hardwired to zero.
- PC_W, 32, program counter width.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_valid  in  1  IF/ID holds a valid instruction.
- i_rs, i_rt, i_rd  in  REG_AW each  source/destination fields.
- i_use_rs, i_use_rt  in  1 each  instruction reads rs/rt.
- i_regdst  in  1  destination select: 1 = rd, 0 = rt.
- i_regwrite  in  1  instruction writes a register.
- i_beq, i_bne  in  1 each  branch type.
- i_pc  in  PC_W  PC of the instruction in ID.
- i_imm16  in  16  branch offset.
- i_ex_we, i_ex_load  in  1 each  EX-stage instruction writes a register / is a load.
- i_ex_waddr  in  REG_AW  EX-stage destination.
- i_ex_data  in  DATA_W  EX-stage ALU result.
- i_mem_we  in  1  MEM-stage instruction writes a register.
- i_mem_waddr  in  REG_AW  MEM-stage destination.
- i_mem_data  in  DATA_W  MEM-stage result.
- i_wb_we  in  1  WB write enable.
- i_wb_waddr  in  REG_AW  WB destination.
- i_wb_data  in  DATA_W  WB data.
- i_hold  in  1  downstream not ready; freeze the output register.
- i_flush  in  1  exception/kill; insert a bubble.
- o_stall  out  1  hold IF/ID and PC.
- o_pcsrc  out  1  branch taken.
- o_next_pc  out  PC_W  branch target.
- o_valid  out  1  registered: ID/EX valid.
- o_op1, o_op2  out  DATA_W each  registered forwarded operands.
- o_waddr  out  REG_AW  registered destination.
- o_we  out  1  registered write enable, qualified by o_valid.

Behaviour:
- Register file:
  - Written at the clock edge when i_wb_we=1 and i_wb_waddr!=0.
  - Reads are combinational.
  - Write to address 0 is ignored.
  - On i_rst, all entries clear to 0.
- Operand select, per source (rs/rt), in priority order:
  1. Address 0 → 0.
  2. i_ex_we & waddr match & !i_ex_load → i_ex_data.
  3. i_mem_we & match → i_mem_data.
  4. i_wb_we & match → i_wb_data (same-cycle write-through).
  5. Otherwise → register file.
- Load-use hazard (lu):
  - lu = i_valid & i_ex_we & i_ex_load & i_ex_waddr!=0 & ((i_use_rs & rs==i_ex_waddr) | (i_use_rt & rt==i_ex_waddr)).
  - Also asserted for branches whose compared operand matches the EX load.
- o_stall = lu | i_hold. Combinational.
- Branch:
  - eq = (op1_fwd == op2_fwd).
  - o_pcsrc = i_valid & !o_stall & !i_flush & ((i_beq & eq) | (i_bne & !eq)).
  - o_next_pc = i_pc + 4 + (sign-extended i_imm16 << 2), computed modulo 2**PC_W.
  - o_next_pc is valid whenever o_pcsrc=1.
- Destination: waddr = i_regdst ? i_rd : i_rt.
  - Write enable = i_regwrite & waddr!=0.
- Output register, priority at each edge:
  1. i_rst → o_valid=0, o_op1=0, o_op2=0, o_waddr=0, o_we=0.
  2. i_flush → bubble (o_valid=0, o_we=0); ops and waddr don't-care, driven 0.
  3. i_hold → all outputs keep their value.
  4. lu → bubble.
  5. Otherwise → capture forwarded ops, waddr, we & i_valid, o_valid = i_valid.
- Latency: 1 cycle from ID inputs to o_* registered outputs. o_stall, o_pcsrc and o_next_pc are same-cycle.
- Reset mid-stall clears everything. o_stall is then recomputed from the inputs only.
- Simultaneous i_flush and i_hold: flush wins.

Optional Feature:
- Macro: DECODE_PERF_CNT_EN.
- When defined:
  - Adds output o_stall_cnt (32 bits) and output o_lu_cnt (32 bits).
  - o_stall_cnt increments on every cycle with o_stall=1.
  - o_lu_cnt increments on every cycle with lu=1.
  - Both saturate at 32'hFFFFFFFF.
  - Both clear on i_rst.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset then WB write r5=0x1234 → next-cycle ID read of rs=5 gives o_op1=0x1234 one cycle later. Writing r0=0xFFFF leaves r0 reading 0.
- Forward priority: EX r3=0xA, MEM r3=0xB, WB r3=0xC, rs=3 → o_op1=0xA. With i_ex_we=0 → 0xB. With MEM also off → 0xC.
- Load-use: EX load r7, ID uses rt=7 → o_stall=1 for 1 cycle, o_valid=0 next cycle. Once the load is in MEM, forwarding gives i_mem_data and o_valid=1.
- Branch: beq, op1=op2=5, i_pc=0x100, i_imm16=0xFFFF → o_pcsrc=1, o_next_pc=0x100. bne with the same operands → o_pcsrc=0.
- Hold/flush: i_hold for 3 cycles → o_* frozen. i_hold together with i_flush → o_valid=0 next cycle.
- DECODE_PERF_CNT_EN: 4 stall cycles, 2 of them lu → o_stall_cnt=4, o_lu_cnt=2. Counter preloaded to max stays at 0xFFFFFFFF.

Source files
------------

// File: rtl/decode_fwd_stage.sv
// MIPS-style decode stage: register file, internal forwarding, load-use interlock,
// branch resolution in ID and a registered ID/EX output. DECODE_PERF_CNT_EN adds stall/lu counters.
module decode_fwd_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int PC_W   = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [REG_AW-1:0] i_rs,
    input  logic [REG_AW-1:0] i_rt,
    input  logic [REG_AW-1:0] i_rd,
    input  logic              i_use_rs,
    input  logic              i_use_rt,
    input  logic              i_regdst,
    input  logic              i_regwrite,
    input  logic              i_beq,
    input  logic              i_bne,
    input  logic [PC_W-1:0]   i_pc,
    input  logic [15:0]       i_imm16,
    input  logic              i_ex_we,
    input  logic              i_ex_load,
    input  logic [REG_AW-1:0] i_ex_waddr,
    input  logic [DATA_W-1:0] i_ex_data,
    input  logic              i_mem_we,
    input  logic [REG_AW-1:0] i_mem_waddr,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic              i_wb_we,
    input  logic [REG_AW-1:0] i_wb_waddr,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic              i_hold,
    input  logic              i_flush,
    output logic              o_stall,
    output logic              o_pcsrc,
    output logic [PC_W-1:0]   o_next_pc,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_op1,
    output logic [DATA_W-1:0] o_op2,
    output logic [REG_AW-1:0] o_waddr,
    output logic              o_we
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]       o_stall_cnt,
    output logic [31:0]       o_lu_cnt
`endif
);

    localparam int unsigned NREG = 2 ** REG_AW;
    localparam logic [PC_W-1:0] PC_STEP = 4;

    logic [DATA_W-1:0] rf [NREG];
    logic [DATA_W-1:0] op1_fwd, op2_fwd;
    logic [REG_AW-1:0] waddr;
    logic              we;
    logic              branch, eq, lu;
    logic [PC_W-1:0]   br_off;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (i_wb_we && i_wb_waddr != '0) begin
            rf[i_wb_waddr] <= i_wb_data;
        end
    end

    // Youngest producer wins; an EX load has no data yet and is covered by the interlock.
    function automatic logic [DATA_W-1:0] fwd(input logic [REG_AW-1:0] a);
        if (a == '0)                                        return '0;
        else if (i_ex_we && !i_ex_load && i_ex_waddr == a)  return i_ex_data;
        else if (i_mem_we && i_mem_waddr == a)              return i_mem_data;
        else if (i_wb_we && i_wb_waddr == a)                return i_wb_data;
        return rf[a];
    endfunction

    always_comb begin
        op1_fwd = fwd(i_rs);
        op2_fwd = fwd(i_rt);
    end

    assign branch = i_beq | i_bne;

    // Branches compare both operands in ID, so they count as readers of rs and rt.
    assign lu = i_valid & i_ex_we & i_ex_load & (i_ex_waddr != '0) &
                (((i_use_rs | branch) & (i_rs == i_ex_waddr)) |
                 ((i_use_rt | branch) & (i_rt == i_ex_waddr)));

    assign o_stall = lu | i_hold;

    assign eq      = (op1_fwd == op2_fwd);
    assign o_pcsrc = i_valid & ~o_stall & ~i_flush & ((i_beq & eq) | (i_bne & ~eq));

    assign br_off    = {{(PC_W-18){i_imm16[15]}}, i_imm16, 2'b00};
    assign o_next_pc = i_pc + PC_STEP + br_off;

    assign waddr = i_regdst ? i_rd : i_rt;
    assign we    = i_regwrite & (waddr != '0);

    // Flush beats hold; a load-use bubble only enters when not held.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush || (!i_hold && lu)) begin
            o_valid <= 1'b0;
            o_op1   <= '0;
            o_op2   <= '0;
            o_waddr <= '0;
            o_we    <= 1'b0;
        end else if (!i_hold) begin
            o_valid <= i_valid;
            o_op1   <= op1_fwd;
            o_op2   <= op2_fwd;
            o_waddr <= waddr;
            o_we    <= we & i_valid;
        end
    end

`ifdef DECODE_PERF_CNT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_stall_cnt <= '0;
            o_lu_cnt    <= '0;
        end else begin
            if (o_stall && o_stall_cnt != '1) o_stall_cnt <= o_stall_cnt + 32'd1;
            if (lu && o_lu_cnt != '1)         o_lu_cnt    <= o_lu_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_decode_fwd_stage.sv
// Table-driven directed bench for decode_fwd_stage, plus reset-mid-stall and counter sequences.
module tb_decode_fwd_stage;

    logic        clk = 1'b0;
    logic        rst, valid, use_rs, use_rt, regdst, regwrite, beq, bne;
    logic [4:0]  rs, rt, rd, ex_waddr, mem_waddr, wb_waddr;
    logic [31:0] pc, ex_data, mem_data, wb_data;
    logic [15:0] imm16;
    logic        ex_we, ex_load, mem_we, wb_we, hold, flush;
    logic        stall, pcsrc, o_valid, o_we;
    logic [31:0] next_pc, op1, op2;
    logic [4:0]  o_waddr;
`ifdef DECODE_PERF_CNT_EN
    logic [31:0] stall_cnt, lu_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    decode_fwd_stage #(.DATA_W(32), .REG_AW(5), .PC_W(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid),
        .i_rs(rs), .i_rt(rt), .i_rd(rd),
        .i_use_rs(use_rs), .i_use_rt(use_rt), .i_regdst(regdst), .i_regwrite(regwrite),
        .i_beq(beq), .i_bne(bne), .i_pc(pc), .i_imm16(imm16),
        .i_ex_we(ex_we), .i_ex_load(ex_load), .i_ex_waddr(ex_waddr), .i_ex_data(ex_data),
        .i_mem_we(mem_we), .i_mem_waddr(mem_waddr), .i_mem_data(mem_data),
        .i_wb_we(wb_we), .i_wb_waddr(wb_waddr), .i_wb_data(wb_data),
        .i_hold(hold), .i_flush(flush),
        .o_stall(stall), .o_pcsrc(pcsrc), .o_next_pc(next_pc),
        .o_valid(o_valid), .o_op1(op1), .o_op2(op2), .o_waddr(o_waddr), .o_we(o_we)
`ifdef DECODE_PERF_CNT_EN
        , .o_stall_cnt(stall_cnt), .o_lu_cnt(lu_cnt)
`endif
    );

    typedef struct {
        string       name;
        logic        valid, use_rs, use_rt, regdst, regwrite, beq, bne;
        logic [4:0]  rs, rt, rd;
        logic [31:0] pc;
        logic [15:0] imm;
        logic        ex_we, ex_load;
        logic [4:0]  ex_waddr;
        logic [31:0] ex_data;
        logic        mem_we;
        logic [4:0]  mem_waddr;
        logic [31:0] mem_data;
        logic        wb_we;
        logic [4:0]  wb_waddr;
        logic [31:0] wb_data;
        logic        hold, flush;
        logic        e_stall, e_pcsrc;
        logic [31:0] e_next_pc;
        logic        e_valid;
        logic [31:0] e_op1, e_op2;
        logic [4:0]  e_waddr;
        logic        e_we;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl [NV];

    function automatic vec_t blank(input string name);
        vec_t v;
        v = '{name: name, default: '0};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        valid = v.valid; use_rs = v.use_rs; use_rt = v.use_rt; regdst = v.regdst;
        regwrite = v.regwrite; beq = v.beq; bne = v.bne;
        rs = v.rs; rt = v.rt; rd = v.rd; pc = v.pc; imm16 = v.imm;
        ex_we = v.ex_we; ex_load = v.ex_load; ex_waddr = v.ex_waddr; ex_data = v.ex_data;
        mem_we = v.mem_we; mem_waddr = v.mem_waddr; mem_data = v.mem_data;
        wb_we = v.wb_we; wb_waddr = v.wb_waddr; wb_data = v.wb_data;
        hold = v.hold; flush = v.flush;
    endtask

    task automatic chk_regs(input string name, input logic ev, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [4:0] ew, input logic ewe);
        chk({name, ".valid"}, {31'd0, o_valid}, {31'd0, ev});
        chk({name, ".op1"},   op1, e1);
        chk({name, ".op2"},   op2, e2);
        chk({name, ".waddr"}, {27'd0, o_waddr}, {27'd0, ew});
        chk({name, ".we"},    {31'd0, o_we}, {31'd0, ewe});
    endtask

    initial begin
        // 0-3: register file write/read and r0 hardwiring
        tbl[0] = blank("wr_r5");
        tbl[0].wb_we = 1; tbl[0].wb_waddr = 5; tbl[0].wb_data = 32'h1234;
        tbl[1] = blank("rd_r5");
        tbl[1].valid = 1; tbl[1].rs = 5; tbl[1].use_rs = 1; tbl[1].regdst = 1; tbl[1].rd = 2;
        tbl[1].regwrite = 1;
        tbl[1].e_valid = 1; tbl[1].e_op1 = 32'h1234; tbl[1].e_waddr = 2; tbl[1].e_we = 1;
        tbl[2] = blank("wr_r0");
        tbl[2].wb_we = 1; tbl[2].wb_waddr = 0; tbl[2].wb_data = 32'hFFFF;
        tbl[3] = blank("rd_r0");
        tbl[3].valid = 1; tbl[3].rs = 0; tbl[3].rt = 5; tbl[3].use_rs = 1; tbl[3].use_rt = 1;
        tbl[3].regwrite = 1;
        tbl[3].e_valid = 1; tbl[3].e_op2 = 32'h1234; tbl[3].e_waddr = 5; tbl[3].e_we = 1;
        // 4-7: forwarding priority EX > MEM > WB > regfile
        tbl[4] = blank("fwd_ex");
        tbl[4].valid = 1; tbl[4].rs = 3; tbl[4].use_rs = 1;
        tbl[4].ex_we = 1; tbl[4].ex_waddr = 3; tbl[4].ex_data = 32'hA;
        tbl[4].mem_we = 1; tbl[4].mem_waddr = 3; tbl[4].mem_data = 32'hB;
        tbl[4].wb_we = 1; tbl[4].wb_waddr = 3; tbl[4].wb_data = 32'hC;
        tbl[4].e_valid = 1; tbl[4].e_op1 = 32'hA;
        tbl[5] = tbl[4]; tbl[5].name = "fwd_mem"; tbl[5].ex_we = 0; tbl[5].e_op1 = 32'hB;
        tbl[6] = tbl[5]; tbl[6].name = "fwd_wb"; tbl[6].mem_we = 0; tbl[6].e_op1 = 32'hC;
        tbl[7] = blank("rf_r3");
        tbl[7].valid = 1; tbl[7].rs = 3; tbl[7].use_rs = 1; tbl[7].e_valid = 1; tbl[7].e_op1 = 32'hC;
        // 8-9: load-use interlock, then MEM forwarding of the load
        tbl[8] = blank("lu");
        tbl[8].valid = 1; tbl[8].rt = 7; tbl[8].use_rt = 1; tbl[8].regdst = 1; tbl[8].rd = 8;
        tbl[8].regwrite = 1;
        tbl[8].ex_we = 1; tbl[8].ex_load = 1; tbl[8].ex_waddr = 7; tbl[8].ex_data = 32'hDEAD;
        tbl[8].e_stall = 1;
        tbl[9] = tbl[8]; tbl[9].name = "lu_mem";
        tbl[9].ex_we = 0; tbl[9].ex_load = 0; tbl[9].ex_waddr = 0; tbl[9].ex_data = 0;
        tbl[9].mem_we = 1; tbl[9].mem_waddr = 7; tbl[9].mem_data = 32'h77;
        tbl[9].e_stall = 0; tbl[9].e_valid = 1; tbl[9].e_op2 = 32'h77; tbl[9].e_waddr = 8;
        tbl[9].e_we = 1;
        // 10-13: branches
        tbl[10] = blank("beq_taken");
        tbl[10].valid = 1; tbl[10].beq = 1; tbl[10].rs = 3; tbl[10].rt = 6;
        tbl[10].use_rs = 1; tbl[10].use_rt = 1; tbl[10].pc = 32'h100; tbl[10].imm = 16'hFFFF;
        tbl[10].ex_we = 1; tbl[10].ex_waddr = 3; tbl[10].ex_data = 5;
        tbl[10].mem_we = 1; tbl[10].mem_waddr = 6; tbl[10].mem_data = 5;
        tbl[10].e_pcsrc = 1; tbl[10].e_next_pc = 32'h100;
        tbl[10].e_valid = 1; tbl[10].e_op1 = 5; tbl[10].e_op2 = 5; tbl[10].e_waddr = 6;
        tbl[11] = tbl[10]; tbl[11].name = "bne_same"; tbl[11].beq = 0; tbl[11].bne = 1;
        tbl[11].e_pcsrc = 0;
        tbl[12] = tbl[11]; tbl[12].name = "bne_taken"; tbl[12].mem_data = 6;
        tbl[12].pc = 32'h200; tbl[12].imm = 16'h0010;
        tbl[12].e_pcsrc = 1; tbl[12].e_next_pc = 32'h244; tbl[12].e_op2 = 6;
        tbl[13] = blank("br_lu");
        tbl[13].valid = 1; tbl[13].beq = 1; tbl[13].rs = 9;
        tbl[13].ex_we = 1; tbl[13].ex_load = 1; tbl[13].ex_waddr = 9;
        tbl[13].e_stall = 1;
        // 14-19: hold and flush
        tbl[14] = blank("capture");
        tbl[14].valid = 1; tbl[14].rs = 3; tbl[14].rt = 5; tbl[14].regdst = 1; tbl[14].rd = 10;
        tbl[14].regwrite = 1;
        tbl[14].e_valid = 1; tbl[14].e_op1 = 32'hC; tbl[14].e_op2 = 32'h1234;
        tbl[14].e_waddr = 10; tbl[14].e_we = 1;
        for (int i = 15; i < 18; i++) begin
            tbl[i] = tbl[14]; tbl[i].name = "hold";
            tbl[i].hold = 1; tbl[i].beq = 1; tbl[i].rs = 5; tbl[i].rt = 5; tbl[i].rd = 11;
            tbl[i].e_stall = 1;
        end
        tbl[18] = tbl[15]; tbl[18].name = "hold_flush"; tbl[18].flush = 1;
        tbl[18].e_valid = 0; tbl[18].e_op1 = 0; tbl[18].e_op2 = 0; tbl[18].e_waddr = 0;
        tbl[18].e_we = 0;
        tbl[19] = tbl[18]; tbl[19].name = "flush"; tbl[19].hold = 0; tbl[19].e_stall = 0;
        tbl[20] = blank("after_flush");
        tbl[20].valid = 1; tbl[20].rs = 5; tbl[20].rt = 3; tbl[20].regwrite = 1;
        tbl[20].e_valid = 1; tbl[20].e_op1 = 32'h1234; tbl[20].e_op2 = 32'hC;
        tbl[20].e_waddr = 3; tbl[20].e_we = 1;
        tbl[21] = blank("invalid_we");
        tbl[21].rs = 5; tbl[21].regdst = 1; tbl[21].rd = 4; tbl[21].regwrite = 1;
        tbl[21].e_op1 = 32'h1234; tbl[21].e_waddr = 4;

        drive(blank("idle"));
        rst = 1;
        @(posedge clk); @(posedge clk); #1;
        chk_regs("reset", 0, 0, 0, 0, 0);
        chk("reset.stall", {31'd0, stall}, 0);
        rst = 0;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            chk({tbl[i].name, ".stall"}, {31'd0, stall}, {31'd0, tbl[i].e_stall});
            chk({tbl[i].name, ".pcsrc"}, {31'd0, pcsrc}, {31'd0, tbl[i].e_pcsrc});
            if (tbl[i].e_pcsrc) chk({tbl[i].name, ".next_pc"}, next_pc, tbl[i].e_next_pc);
            @(posedge clk); #1;
            chk_regs(tbl[i].name, tbl[i].e_valid, tbl[i].e_op1, tbl[i].e_op2,
                     tbl[i].e_waddr, tbl[i].e_we);
        end

        // Reset while a load-use stall is pending: outputs and regfile clear, stall follows inputs.
        drive(tbl[8]);
        rst = 1;
        @(negedge clk);
        chk("rst_lu.stall", {31'd0, stall}, 1);
        @(posedge clk); #1;
        chk_regs("rst_lu", 0, 0, 0, 0, 0);
        rst = 0;
        drive(tbl[7]);
        @(negedge clk);
        chk("rst_rf.stall", {31'd0, stall}, 0);
        @(posedge clk); #1;
        chk_regs("rst_rf", 1, 0, 0, 0, 0);

`ifdef DECODE_PERF_CNT_EN
        chk("cnt.stall0", stall_cnt, 0);
        chk("cnt.lu0", lu_cnt, 0);
        drive(tbl[8]);
        @(posedge clk); @(posedge clk); #1;
        drive(tbl[15]);
        @(posedge clk); @(posedge clk); #1;
        drive(blank("idle"));
        @(posedge clk); #1;
        chk("cnt.stall4", stall_cnt, 4);
        chk("cnt.lu2", lu_cnt, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
